ram_2port_bist: RTL and testbench
=================================

Name: ram_2port_bist

Overview:
Synthesizable initiator for the dual-port RAM write and read interfaces, used as a memory self-test engine. On a start pulse it fills every address with a deterministic pattern through the write port. It then reads every address back through the read port and compares each returned word against the expected value. It reports pass/fail, error count and first failing address. It sits between the control/status logic and one RAM_2Port instance, owning both of that RAM's ports while active.

Parameters:
WIDTH, 8, data width in bits; must match the attached RAM.
DEPTH, 16, number of words; must match the attached RAM.
SEED, 8'h10, pattern offset: expected data = (addr + SEED) truncated to WIDTH.
RD_TIMEOUT, 16, idle cycles allowed in DRAIN with no i_Rd_DV before declaring timeout.
ERR_W, 8, width of error counter.

Ports:
i_Clk  in  1  clock; single clock domain, also drives both RAM port clocks
i_Rst_L  in  1  asynchronous active-low reset
i_Start  in  1  single-cycle start request
o_Wr_Addr  out  $clog2(DEPTH)  RAM write address
o_Wr_DV  out  1  RAM write strobe
o_Wr_Data  out  WIDTH  RAM write data
o_Rd_Addr  out  $clog2(DEPTH)  RAM read address
o_Rd_En  out  1  RAM read enable
i_Rd_DV  in  1  RAM read data valid
i_Rd_Data  in  WIDTH  RAM read data
o_Busy  out  1  test in progress
o_Done  out  1  one-cycle pulse at test completion
o_Pass  out  1  level; 1 = last test clean
o_Timeout  out  1  level; last test ended on read timeout
o_Err_Count  out  ERR_W  mismatches in last test, saturating
o_Fail_Valid  out  1  o_Fail_Addr holds a captured address
o_Fail_Addr  out  $clog2(DEPTH)  address of first mismatch

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM = IDLE, all counters 0. Reset mid-test aborts immediately with no partial status retained.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: i_Start=1 clears all status outputs and enters WRITE on the next edge. o_Busy is 1 from the first WRITE cycle until DONE exits.
- WRITE: o_Wr_DV=1 for exactly DEPTH consecutive cycles. o_Wr_Addr runs 0..DEPTH-1 and o_Wr_Data = addr+SEED. After the last address, go to READ; o_Wr_DV is 0 in that cycle.
- READ: o_Rd_En=1 for exactly DEPTH consecutive cycles, with o_Rd_Addr running 0..DEPTH-1. The write and read ports are never active in the same cycle. Then go to DRAIN.
- Compare (READ and DRAIN): each i_Rd_DV beat is checked against cmp_cnt+SEED, where cmp_cnt is an independent counter starting at 0 and incremented per beat. The engine tolerates any RAM read latency ≥1.
  - On a mismatch, o_Err_Count increments and saturates at 2^ERR_W-1.
  - On the first mismatch, o_Fail_Addr = cmp_cnt and o_Fail_Valid = 1.
  - i_Rd_DV is ignored in IDLE, WRITE and DONE.
- DRAIN: exits to DONE when cmp_cnt == DEPTH. A timeout counter resets on every i_Rd_DV. When it reaches RD_TIMEOUT, set o_Timeout=1 and go to DONE.
- DONE: lasts one cycle. o_Done=1 and o_Busy drops to 0 on the next cycle. o_Pass = (err==0 && !timeout). Then return to IDLE.
- Status outputs hold until the next accepted start.
- i_Start outside IDLE is ignored; there are no queued starts.
- Address counters wrap via a terminal-count compare, so non-power-of-2 DEPTH is supported.

Optional Feature:
Macro BIST_INVERT_PASS_EN.
- Defined: after the first DRAIN completes without timeout, run a second WRITE/READ/DRAIN sequence with data = ~(addr+SEED).
  - cmp_cnt and the timeout counter reset between passes. The error count and first-fail capture accumulate across both passes.
  - A timeout in the second pass still ends in DONE.
- Undefined: a single true-pattern pass only, with no extra logic.

Test Plan:
1. DEPTH=4, WIDTH=8, SEED=8'h10, real RAM_2Port, pulse i_Start -> writes 10,11,12,13 to addresses 0..3, then 4 reads. o_Done within 2*DEPTH+4 cycles of start; o_Pass=1, o_Err_Count=0, o_Fail_Valid=0.
2. Same setup, bench XORs i_Rd_Data bit0 on the beat for address 2 -> o_Pass=0, o_Err_Count=1, o_Fail_Valid=1, o_Fail_Addr=2.
3. i_Rd_DV tied 0 -> DONE exactly RD_TIMEOUT cycles after DRAIN entry; o_Timeout=1, o_Pass=0, o_Err_Count=0.
4. i_Start pulsed in WRITE -> ignored, single run only. Start after DONE (with a test-2 failure still latched) -> status cleared in the first WRITE cycle; a clean rerun gives o_Pass=1.
5. i_Rst_L asserted in WRITE at addr 2 -> o_Wr_DV and all outputs 0 immediately. After release and a new start, a full pass completes with o_Pass=1.
6. With BIST_INVERT_PASS_EN: test 1 sees writes EF,EE,ED,EC in the second pass and 8 total compare beats, with o_Pass=1. Corrupting one second-pass beat gives o_Err_Count=1.

Source files
------------

// File: rtl/ram_2port_bist_if.sv
// ram_2port_bist_if
//   Bundles the write and read ports of one RAM_2Port instance.
//   master : self-test engine side (drives write port and read request,
//            receives read data)
//   slave  : RAM side
// Signals
//   o_Wr_Addr, o_Wr_DV, o_Wr_Data : write port (address, strobe, data)
//   o_Rd_Addr, o_Rd_En            : read request (address, enable)
//   i_Rd_DV, i_Rd_Data            : read return (valid, data)
interface ram_2port_bist_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    o_Wr_Addr;
    logic             o_Wr_DV;
    logic [WIDTH-1:0] o_Wr_Data;
    logic [AW-1:0]    o_Rd_Addr;
    logic             o_Rd_En;
    logic             i_Rd_DV;
    logic [WIDTH-1:0] i_Rd_Data;

    modport master (
        output o_Wr_Addr, o_Wr_DV, o_Wr_Data, o_Rd_Addr, o_Rd_En,
        input  i_Rd_DV, i_Rd_Data
    );

    modport slave (
        input  o_Wr_Addr, o_Wr_DV, o_Wr_Data, o_Rd_Addr, o_Rd_En,
        output i_Rd_DV, i_Rd_Data
    );
endinterface

// File: rtl/ram_2port_bist.sv
// ram_2port_bist
//   Memory self-test engine for one dual-port RAM. A start pulse fills every
//   address with (addr + SEED) through the write port, reads every address
//   back through the read port and checks each returned word in arrival
//   order. Reports pass/fail, a saturating error count, the first failing
//   address and a read-timeout flag.
// Optional feature
//   BIST_INVERT_PASS_EN : when defined, a clean first pass (no timeout) is
//   followed by a second write/read pass using ~(addr + SEED). Error count
//   and first-fail capture accumulate over both passes.
// Ports
//   i_Clk, i_Rst_L  : clock, asynchronous active-low reset
//   i_Start         : single-cycle start request (honoured only when idle)
//   ram             : RAM write/read ports (ram_2port_bist_if.master)
//   o_Busy          : test in progress
//   o_Done          : one-cycle completion pulse
//   o_Pass          : last test clean (no mismatch, no timeout)
//   o_Timeout       : last test ended on read timeout
//   o_Err_Count     : mismatch count, saturating
//   o_Fail_Valid    : o_Fail_Addr holds a captured address
//   o_Fail_Addr     : address of first mismatch
module ram_2port_bist #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 16,
    parameter logic [WIDTH-1:0] SEED       = WIDTH'(8'h10),
    parameter int               RD_TIMEOUT = 16,
    parameter int               ERR_W      = 8,
    localparam int              AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Start,
    ram_2port_bist_if.master   ram,
    output logic               o_Busy,
    output logic               o_Done,
    output logic               o_Pass,
    output logic               o_Timeout,
    output logic [ERR_W-1:0]   o_Err_Count,
    output logic               o_Fail_Valid,
    output logic [AW-1:0]      o_Fail_Addr
);
    // cmp_cnt must be able to hold DEPTH itself (the "all beats seen" value)
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state;
    logic [AW-1:0] addr;
    logic [CW-1:0] cmp_cnt;
    logic [TW-1:0] to_cnt;

`ifdef BIST_INVERT_PASS_EN
    logic inv_pass;
`else
    localparam logic inv_pass = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] pattern(input logic [CW-1:0] idx,
                                                  input logic inv);
        logic [WIDTH-1:0] p;
        p = WIDTH'(idx) + SEED;
        return inv ? ~p : p;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic last_addr;
    logic drain_done;
    logic rd_beat;
    logic mismatch;

    assign last_addr  = (addr == AW'(DEPTH - 1));
    assign drain_done = (cmp_cnt == CW'(DEPTH));
    // Beats beyond DEPTH in one pass are not part of the test and are dropped
    assign rd_beat    = ram.i_Rd_DV && !drain_done &&
                        ((state == S_READ) || (state == S_DRAIN));
    assign mismatch   = rd_beat && (ram.i_Rd_Data != pattern(cmp_cnt, inv_pass));

    // Port outputs are decoded from registered state; idle ports drive zero
    assign ram.o_Wr_DV   = (state == S_WRITE);
    assign ram.o_Wr_Addr = ram.o_Wr_DV ? addr : '0;
    assign ram.o_Wr_Data = ram.o_Wr_DV ? pattern(CW'(addr), inv_pass) : '0;
    assign ram.o_Rd_En   = (state == S_READ);
    assign ram.o_Rd_Addr = ram.o_Rd_En ? addr : '0;
    assign o_Busy        = (state != S_IDLE);
    assign o_Done        = (state == S_DONE);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state        <= S_IDLE;
            addr         <= '0;
            cmp_cnt      <= '0;
            to_cnt       <= '0;
            o_Pass       <= 1'b0;
            o_Timeout    <= 1'b0;
            o_Err_Count  <= '0;
            o_Fail_Valid <= 1'b0;
            o_Fail_Addr  <= '0;
`ifdef BIST_INVERT_PASS_EN
            inv_pass     <= 1'b0;
`endif
        end else begin
            // Compare path runs independently of the address counter so any
            // read latency of one cycle or more is tolerated
            if (rd_beat) begin
                cmp_cnt <= cmp_cnt + 1'b1;
                if (mismatch) begin
                    o_Err_Count <= sat_inc(o_Err_Count);
                    if (!o_Fail_Valid) begin
                        o_Fail_Valid <= 1'b1;
                        o_Fail_Addr  <= AW'(cmp_cnt);
                    end
                end
            end

            case (state)
                S_IDLE: begin
                    if (i_Start) begin
                        o_Pass       <= 1'b0;
                        o_Timeout    <= 1'b0;
                        o_Err_Count  <= '0;
                        o_Fail_Valid <= 1'b0;
                        o_Fail_Addr  <= '0;
                        addr         <= '0;
                        cmp_cnt      <= '0;
                        to_cnt       <= '0;
`ifdef BIST_INVERT_PASS_EN
                        inv_pass     <= 1'b0;
`endif
                        state        <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (last_addr) begin
                        addr  <= '0;
                        state <= S_READ;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                S_READ: begin
                    if (last_addr) begin
                        addr   <= '0;
                        to_cnt <= '0;
                        state  <= S_DRAIN;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
`ifdef BIST_INVERT_PASS_EN
                        if (!inv_pass) begin
                            inv_pass <= 1'b1;
                            cmp_cnt  <= '0;
                            to_cnt   <= '0;
                            state    <= S_WRITE;
                        end else
`endif
                        begin
                            o_Pass <= (o_Err_Count == '0);
                            state  <= S_DONE;
                        end
                    end else if (ram.i_Rd_DV) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TW'(RD_TIMEOUT - 1)) begin
                        o_Timeout <= 1'b1;
                        o_Pass    <= 1'b0;
                        state     <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_2port_bist.sv
// tb_ram_2port_bist
//   Drives ram_2port_bist against a behavioural dual-port RAM with selectable
//   read latency, beat corruption and read-valid suppression. Table vectors,
//   hand-written start/reset sequences and randomized runs are compared with
//   expectations derived from the test rules.
module tb_ram_2port_bist;
    localparam int         W    = 8;
    localparam int         D    = 4;
    localparam int         TO   = 16;
    localparam int         EW   = 2;
    localparam logic [7:0] SEED = 8'h10;
    localparam int         SAT  = (1 << EW) - 1;
`ifdef BIST_INVERT_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic          i_Clk = 1'b0;
    logic          i_Rst_L = 1'b0;
    logic          i_Start = 1'b0;
    logic          o_Busy, o_Done, o_Pass, o_Timeout, o_Fail_Valid;
    logic [EW-1:0] o_Err_Count;
    logic [1:0]    o_Fail_Addr;

    always #5 i_Clk = ~i_Clk;

    ram_2port_bist_if #(.WIDTH(W), .DEPTH(D)) ram_if ();

    ram_2port_bist #(
        .WIDTH(W), .DEPTH(D), .SEED(SEED), .RD_TIMEOUT(TO), .ERR_W(EW)
    ) dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Start(i_Start), .ram(ram_if),
        .o_Busy(o_Busy), .o_Done(o_Done), .o_Pass(o_Pass),
        .o_Timeout(o_Timeout), .o_Err_Count(o_Err_Count),
        .o_Fail_Valid(o_Fail_Valid), .o_Fail_Addr(o_Fail_Addr)
    );

    // Behavioural RAM with read latency lat_sel (1..4)
    logic [W-1:0] mem [D];
    logic         dv_pipe [4];
    logic [W-1:0] d_pipe [4];
    int           lat_sel = 1;
    logic [31:0]  cmask = '0;
    logic         kill = 1'b0;
    logic [W-1:0] xval = 8'h01;
    int           beat_total = 0;
    int           beat_base = 0;
    int           corr_off;
    logic         rd_dv_c;
    logic [W-1:0] rd_data_c;

    always @(posedge i_Clk) begin
        if (ram_if.o_Wr_DV) mem[ram_if.o_Wr_Addr] <= ram_if.o_Wr_Data;
        dv_pipe[0] <= i_Rst_L && ram_if.o_Rd_En;
        d_pipe[0]  <= mem[ram_if.o_Rd_Addr];
        for (int k = 1; k < 4; k++) begin
            dv_pipe[k] <= i_Rst_L && dv_pipe[k-1];
            d_pipe[k]  <= d_pipe[k-1];
        end
        if (ram_if.i_Rd_DV) beat_total <= beat_total + 1;
    end

    always_comb begin
        corr_off  = beat_total - beat_base;
        rd_dv_c   = dv_pipe[lat_sel-1] && !kill;
        rd_data_c = d_pipe[lat_sel-1];
        if (corr_off >= 0 && corr_off < 32)
            if (cmask[corr_off]) rd_data_c = rd_data_c ^ xval;
    end

    assign ram_if.i_Rd_DV   = rd_dv_c;
    assign ram_if.i_Rd_Data = rd_data_c;

    // Port activity log
    int           wr_addr_q [$];
    logic [W-1:0] wr_data_q [$];
    int           rd_addr_q [$];
    int           overlap = 0;

    always @(posedge i_Clk) begin
        if (ram_if.o_Wr_DV) begin
            wr_addr_q.push_back(int'(ram_if.o_Wr_Addr));
            wr_data_q.push_back(ram_if.o_Wr_Data);
        end
        if (ram_if.o_Rd_En) rd_addr_q.push_back(int'(ram_if.o_Rd_Addr));
        if (ram_if.o_Wr_DV && ram_if.o_Rd_En) overlap <= overlap + 1;
    end

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Expected write data for the i-th write of a run
    function automatic logic [W-1:0] exp_wr(input int i);
        logic [W-1:0] p;
        p = W'(i % D) + SEED;
        return (i >= D) ? ~p : p;
    endfunction

    // Reference outcome from the test rules: every delivered beat in order is
    // the next address; corrupted beats are mismatches.
    task automatic model(input logic [31:0] mask, input logic kl,
                         output logic e_pass, output int e_err,
                         output logic e_fv, output int e_fa, output logic e_to);
        int nb, cnt;
        nb = kl ? 0 : PASSES * D;
        cnt = 0; e_fv = 1'b0; e_fa = 0;
        for (int i = 0; i < nb; i++) begin
            if (mask[i]) begin
                if (!e_fv) e_fa = i % D;
                e_fv = 1'b1;
                cnt++;
            end
        end
        e_err  = (cnt > SAT) ? SAT : cnt;
        e_to   = kl;
        e_pass = (cnt == 0) && !kl;
    endtask

    task automatic run_test(input string nm, input int lat, input logic [31:0] mask,
                            input logic kl, input logic [W-1:0] xv, input int restart_at,
                            input logic e_pass, input int e_err, input logic e_fv,
                            input int e_fa, input logic e_to);
        int n, pr, wb, rb, ob, limit, bad;
        @(negedge i_Clk);
        lat_sel = lat; cmask = mask; kill = kl; xval = xv; beat_base = beat_total;
        wb = wr_addr_q.size(); rb = rd_addr_q.size(); ob = overlap;
        pr = kl ? 1 : PASSES;
        i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        n = 1;
        chk({nm, ".busy_first"}, o_Busy, 1);
        chk({nm, ".clear_first"}, {o_Pass, o_Timeout, o_Fail_Valid, o_Err_Count}, 0);
        limit = PASSES * (2 * D + 8) + TO + 8;
        while (!o_Done && n < limit) begin
            @(negedge i_Clk);
            n++;
            i_Start = (n == restart_at);
        end
        i_Start = 1'b0;
        if (!o_Done) begin
            nvec++; nmis++;
            $display("FAIL %s.done_seen: no o_Done within %0d cycles", nm, limit);
            return;
        end
        if (kl) chk({nm, ".timeout_cycle"}, n, 2 * D + 1 + TO);
        else    chk({nm, ".done_in_bound"}, n <= pr * (2 * D + lat + 3), 1);
        chk({nm, ".pass"}, o_Pass, e_pass);
        chk({nm, ".err_count"}, o_Err_Count, e_err);
        chk({nm, ".fail_valid"}, o_Fail_Valid, e_fv);
        chk({nm, ".timeout"}, o_Timeout, e_to);
        if (e_fv) chk({nm, ".fail_addr"}, o_Fail_Addr, e_fa);
        @(negedge i_Clk);
        chk({nm, ".done_pulse_busy_drop"}, {o_Done, o_Busy}, 0);
        chk({nm, ".status_hold"}, {o_Pass, o_Timeout, o_Fail_Valid, o_Err_Count},
            {e_pass, e_to, e_fv, EW'(e_err)});
        chk({nm, ".wr_count"}, wr_addr_q.size() - wb, pr * D);
        bad = 0;
        for (int i = 0; i < wr_addr_q.size() - wb; i++)
            if (wr_addr_q[wb+i] != i % D || wr_data_q[wb+i] != exp_wr(i)) bad++;
        chk({nm, ".wr_sequence_errs"}, bad, 0);
        chk({nm, ".rd_count"}, rd_addr_q.size() - rb, pr * D);
        bad = 0;
        for (int i = 0; i < rd_addr_q.size() - rb; i++)
            if (rd_addr_q[rb+i] != i % D) bad++;
        chk({nm, ".rd_sequence_errs"}, bad, 0);
        chk({nm, ".port_overlap"}, overlap - ob, 0);
    endtask

    typedef struct {
        int          lat;
        logic [31:0] mask;
        logic        kl;
        logic        e_pass;
        int          e_err;
        logic        e_fv;
        int          e_fa;
        logic        e_to;
    } vec_t;

    vec_t tbl [$];

    initial begin
        logic        ep, efv, eto;
        int          ee, efa, k, busy_cycles;
        logic [31:0] m;
        logic        kl;
        int          lat;

        // lat, mask, kill, pass, err, fail_valid, fail_addr, timeout
        tbl.push_back('{1, 32'h0,  1'b0, 1'b1, 0, 1'b0, 0, 1'b0});
        tbl.push_back('{1, 32'h4,  1'b0, 1'b0, 1, 1'b1, 2, 1'b0});
        tbl.push_back('{1, 32'h0,  1'b0, 1'b1, 0, 1'b0, 0, 1'b0});
        tbl.push_back('{3, 32'hA,  1'b0, 1'b0, 2, 1'b1, 1, 1'b0});
        tbl.push_back('{2, 32'h0,  1'b1, 1'b0, 0, 1'b0, 0, 1'b1});
        tbl.push_back('{1, 32'hF,  1'b0, 1'b0, SAT, 1'b1, 0, 1'b0});
        tbl.push_back('{2, 32'h8,  1'b0, 1'b0, 1, 1'b1, 3, 1'b0});
        tbl.push_back('{4, 32'h0,  1'b0, 1'b1, 0, 1'b0, 0, 1'b0});
`ifdef BIST_INVERT_PASS_EN
        tbl.push_back('{1, 32'h10, 1'b0, 1'b0, 1, 1'b1, 0, 1'b0});
        tbl.push_back('{2, 32'h41, 1'b0, 1'b0, 2, 1'b1, 0, 1'b0});
        tbl.push_back('{1, 32'hF0, 1'b0, 1'b0, SAT, 1'b1, 0, 1'b0});
`endif

        // Reset state
        repeat (2) @(posedge i_Clk);
        #1;
        chk("reset.ports", {ram_if.o_Wr_DV, ram_if.o_Wr_Addr, ram_if.o_Wr_Data,
                            ram_if.o_Rd_En, ram_if.o_Rd_Addr}, 0);
        chk("reset.status", {o_Busy, o_Done, o_Pass, o_Timeout, o_Err_Count,
                             o_Fail_Valid, o_Fail_Addr}, 0);
        @(negedge i_Clk);
        i_Rst_L = 1'b1;

        foreach (tbl[i])
            run_test($sformatf("vec%0d", i), tbl[i].lat, tbl[i].mask, tbl[i].kl, 8'h01, 0,
                     tbl[i].e_pass, tbl[i].e_err, tbl[i].e_fv, tbl[i].e_fa, tbl[i].e_to);

        // Start pulsed during WRITE is ignored: one run, then the engine stays idle
        run_test("start_in_write", 1, 32'h0, 1'b0, 8'h01, 3, 1'b1, 0, 1'b0, 0, 1'b0);
        busy_cycles = 0;
        repeat (3 * D) begin
            @(negedge i_Clk);
            if (o_Busy || o_Done) busy_cycles++;
        end
        chk("start_in_write.no_second_run", busy_cycles, 0);

        // Fail run leaves status latched, then reset mid-WRITE at address 2
        run_test("pre_reset_fail", 1, 32'h2, 1'b0, 8'h80, 0, 1'b0, 1, 1'b1, 1, 1'b0);
        @(negedge i_Clk);
        i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        k = 0;
        while (!(ram_if.o_Wr_DV && ram_if.o_Wr_Addr == 2'd2) && k < 20) begin
            @(negedge i_Clk);
            k++;
        end
        chk("reset_mid.reached_addr2", k < 20, 1);
        #2 i_Rst_L = 1'b0;
        #1;
        chk("reset_mid.ports", {ram_if.o_Wr_DV, ram_if.o_Wr_Addr, ram_if.o_Wr_Data,
                                ram_if.o_Rd_En, ram_if.o_Rd_Addr}, 0);
        chk("reset_mid.status", {o_Busy, o_Done, o_Pass, o_Timeout, o_Err_Count,
                                 o_Fail_Valid, o_Fail_Addr}, 0);
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        run_test("after_reset", 1, 32'h0, 1'b0, 8'h01, 0, 1'b1, 0, 1'b0, 0, 1'b0);

        // Randomized runs against the reference model
        for (int r = 0; r < 24; r++) begin
            lat = $urandom_range(1, 4);
            kl  = ($urandom_range(0, 7) == 0);
            m   = '0;
            for (int b = 0; b < PASSES * D; b++)
                if ($urandom_range(0, 3) == 0) m[b] = 1'b1;
            model(m, kl, ep, ee, efv, efa, eto);
            run_test($sformatf("rand%0d", r), lat, m, kl, W'($urandom_range(1, 255)), 0,
                     ep, ee, efv, efa, eto);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", nvec);
        $fatal(1, "watchdog");
    end
endmodule
